// File: rtl/dmem_ctrl.sv
// Data-memory controller: a word-addressed store with a fixed access latency.
// It stalls the pipeline while an access is outstanding and pulses done when the access completes.
module dmem_ctrl #(
   parameter int DEPTH   = 64,
   parameter int LATENCY = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        memRead,
   input  logic        memWrite,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        stall,
   output logic        done,
   output logic        err
);

   localparam int IW = $clog2(DEPTH);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t          state;
   logic [2:0]      cnt;
   logic [IW-1:0]   cap_idx;
   logic            cap_mis;
   logic            cap_wr;
   logic [31:0]     cap_wdata;
   logic [31:0]     mem [DEPTH];

   logic            req;
   logic            enter_done;
   logic [IW-1:0]   acc_idx;
   logic            acc_mis;
   logic            acc_wr;
   logic            unused_addr_hi;

   assign req            = memRead | memWrite;
   assign stall          = (state == IDLE && req) || state == BUSY;
   assign unused_addr_hi = ^addr[31:IW+2];

   // With zero latency DONE is entered straight from IDLE, so the live inputs describe the access.
   always_comb begin
      acc_idx = cap_idx;
      acc_mis = cap_mis;
      acc_wr  = cap_wr;
      if (state == IDLE) begin
         acc_idx = addr[IW+1:2];
         acc_mis = |addr[1:0];
         acc_wr  = memWrite;
      end
   end

   always_comb begin
      enter_done = 1'b0;
      if (state == IDLE && req && LATENCY == 0) enter_done = 1'b1;
      if (state == BUSY && cnt <= 3'd1)        enter_done = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= 3'd0;
         cap_idx   <= '0;
         cap_mis   <= 1'b0;
         cap_wr    <= 1'b0;
         cap_wdata <= 32'd0;
         done      <= 1'b0;
         err       <= 1'b0;
         rdata     <= 32'd0;
      end else begin
         done  <= enter_done;
         err   <= enter_done && acc_mis;
         rdata <= (enter_done && !acc_wr && !acc_mis) ? mem[acc_idx] : 32'd0;
         case (state)
            IDLE: begin
               if (req) begin
                  cap_idx   <= addr[IW+1:2];
                  cap_mis   <= |addr[1:0];
                  cap_wr    <= memWrite;
                  cap_wdata <= wdata;
                  cnt       <= 3'(LATENCY);
                  state     <= (LATENCY == 0) ? DONE : BUSY;
               end
            end
            BUSY: begin
               cnt <= cnt - 3'd1;
               if (cnt <= 3'd1) state <= DONE;
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Commit happens on the edge leaving DONE; an asynchronous reset has already left DONE, so nothing lands.
   always_ff @(posedge clk) begin
      if (state == DONE && cap_wr && !cap_mis) mem[cap_idx] <= cap_wdata;
   end

endmodule

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 Parameter DEPTH, default 64, number of 32-bit data words held (power of two, 4..256).
REQ-002 Parameter LATENCY, default 2, added wait cycles per access (0..7).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 memRead  input  1  load request from the control decoder.
REQ-006 memWrite  input  1  store request from the control decoder.
REQ-007 addr  input  32  byte address from the ALU result.
REQ-008 wdata  input  32  store data (rs2).
REQ-009 rdata  output  32  load data, valid only while done=1.
REQ-010 stall  output  1  freezes PC and pipeline while an access is outstanding.
REQ-011 done  output  1  one-cycle access-complete pulse.
REQ-012 err  output  1  misaligned-access flag, valid only while done=1.

Function
REQ-013 FSM states SHALL be IDLE, BUSY and DONE.
REQ-014 req SHALL be defined as memRead | memWrite.
REQ-015 In IDLE with req=1:
  - capture addr, wdata and op (write if memWrite=1, else read);
  - load wait counter with LATENCY;
  - go to BUSY, or to DONE when LATENCY=0.
REQ-016 In BUSY: decrement counter each cycle; go to DONE in the cycle after counter reaches 0, giving exactly LATENCY BUSY cycles.
REQ-017 DONE SHALL last exactly one cycle, then return to IDLE; req sampled during DONE SHALL be ignored (it is the completing instruction).
REQ-018 stall SHALL be combinational: (state==IDLE && req) || state==BUSY; stall SHALL be 0 in DONE.
REQ-019 A request first seen in cycle t SHALL drive stall=1 for cycles t..t+LATENCY and done=1 in cycle t+LATENCY+1.
REQ-020 Word index SHALL be captured addr[2+log2(DEPTH)-1:2]; higher address bits are ignored (address wraps modulo DEPTH words).
REQ-021 Read: rdata = mem[index] during DONE; rdata = 0 in all other cycles.
REQ-022 Write: mem[index] <= captured wdata on the clock edge that ends the DONE cycle; rdata = 0 during DONE.
REQ-023 memRead and memWrite both high SHALL be treated as a write.
REQ-024 Captured addr[1:0] != 0: no memory access, err=1 and rdata=0 during DONE; latency unchanged.
REQ-025 Inputs changing during BUSY SHALL have no effect; captured values are used.
REQ-026 Back-to-back requests: the next request is accepted in the IDLE cycle after DONE, with no extra gap.

Reset
REQ-027 rst_n low SHALL immediately force: state IDLE, counter 0, done=0, err=0, rdata=0, captured registers 0.
REQ-028 Reset during BUSY or DONE SHALL abort the access; a pending write SHALL NOT be committed.
REQ-029 Memory array contents SHALL NOT be altered by reset.
REQ-030 Memory contents after power-up are undefined; the bench writes before reading.

Verification
REQ-031 LATENCY=2, write 0xDEADBEEF to addr 0x10, then read addr 0x10: each access has stall high for 3 cycles, done at cycle 4, read rdata=0xDEADBEEF, err=0.
REQ-032 LATENCY=0: read request -> stall high 1 cycle, done the next cycle; back-to-back read accepted immediately after.
REQ-033 Read addr 0x13 (misaligned) -> done with err=1, rdata=0; memory unchanged on a following aligned read of 0x10.
REQ-034 DEPTH=64, write 0x1234 to addr 0x100 (index wraps to 0) -> read addr 0x0 returns 0x1234.
REQ-035 Write 0xAAAA5555 to 0x20 and assert rst_n low during BUSY; after release, read 0x20 returns the prior value; all outputs 0 during reset.
REQ-036 memRead=memWrite=1 with wdata=0x77 at 0x8 -> treated as write (rdata=0 at done); a following read of 0x8 returns 0x77.
